mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit. It is the datapath stage downstream of the control unit and executes MIPS-style `mult` and `div`.
- The control unit issues a one-cycle start pulse, holds its FSM in a wait state until `done`, then reads `hi_out`/`lo_out` through MEMtoReg for `mfhi`/`mflo`.
- Multiply uses radix-2 Booth; divide uses restoring division on magnitudes followed by a sign fix-up.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_mult  input  1  start-multiply pulse, sampled only in IDLE.
- op_div  input  1  start-divide pulse, sampled only in IDLE.
- a_in  input  WIDTH  operand A (regA_out, rs); multiplicand / dividend.
- b_in  input  WIDTH  operand B (regB_out, rt); multiplier / divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when HI/LO are valid.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.
- div_zero  output  1  sticky divide-by-zero flag; only present when MD_DIVZERO_EXC_EN is defined.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, counter=0.
  - A reset mid-operation aborts the operation; no `done` follows.
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - op_mult=1 → latch a_in/b_in, enter MULT.
  - else op_div=1 → latch, enter DIV.
  - Both high together → multiply wins; op_div is ignored.
  - busy=0.
- Start pulses outside IDLE are ignored. Operands are sampled only on the start edge, so later changes to a_in/b_in have no effect.
- MULT:
  - Product register {P_hi, P_lo, q-1} = {0, b, 0}.
  - Each cycle: examine {P_lo[0], q-1}; 01 → P_hi += A, 10 → P_hi -= A; then arithmetic shift right by 1.
  - Runs exactly WIDTH cycles, then goes to DONE.
  - Full signed 2*WIDTH result. -2^31 * -2^31 gives HI=0x40000000, LO=0.
- DIV:
  - Record sign_q = a[W-1]^b[W-1] and sign_r = a[W-1]; operate on |a| and |b| as unsigned. |−2^31| = 0x80000000.
  - Each cycle: shift {R,Q} left by 1, trial-subtract |b| from R; if non-negative, keep the result and set Q[0]=1.
  - WIDTH cycles, then FIX.
- FIX (1 cycle):
  - Negate Q if sign_q; negate R if sign_r.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - -2^31 / -1 → LO=0x80000000, HI=0 (wrap, no trap).
- DONE (1 cycle):
  - hi_out/lo_out are written on entry to DONE: mult → HI=upper, LO=lower; div → HI=remainder, LO=quotient.
  - done=1 and busy=0 during DONE, then return to IDLE.
  - hi_out/lo_out hold their values until the next completion or reset; they are never updated mid-operation.
- Latency, with the start sampled at edge k: busy is high from edge k+1.
  - Mult: done is high in the cycle following edge k+WIDTH+1 (k+33).
  - Div: done is high in the cycle following edge k+WIDTH+2 (k+34).
- Back-to-back: a start asserted during the DONE cycle is ignored; the earliest accepted start is in the cycle after done.
- Divide by zero, macro undefined: runs the normal algorithm. The result is deterministic: quotient magnitude all-ones, remainder = |a|, with sign fix-up applied.

Optional Feature:
- Macro MD_DIVZERO_EXC_EN.
- Defined:
  - op_div with b_in=0 goes directly IDLE→DONE (done one cycle after the start edge).
  - HI/LO are left unchanged and div_zero is set to 1.
  - div_zero is cleared only by reset or by the next accepted op_mult/op_div. The control unit routes it to its exception path.
- Undefined: the div_zero port is absent, and zero divisors follow the normal DIV/FIX path.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding for IDLE/MULT/DIV/FIX/DONE (3 bits);
  - the WIDTH default;
  - MIPS funct codes MULT=6'h18 and DIV=6'h1a, which the control unit uses to generate op_mult/op_div.
- Sub-module: md_iter_core, a combinational one-step Booth/restoring-division slice selected by mode. The FSM, counter and registers stay in mult_div_unit.

Test Plan:
- Reset mid-MULT: assert reset 10 cycles into a multiply → busy=0 immediately, HI=LO=0, no done pulse.
- mult 7 × -3 → done at k+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB. Also mult 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- div -7 / 2 → done at k+34; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Also div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- op_mult and op_div pulsed together with 3, 5 → multiply is performed: LO=15, HI=0. A start pulse asserted while busy is ignored; exactly one done is seen.
- div 100 / 0 with MD_DIVZERO_EXC_EN → done at k+1, div_zero=1, HI/LO keep their prior values. A following mult clears div_zero.
- div 100 / 0 without the macro → LO=0xFFFFFFFF, HI=100, done at k+34.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: FSM state encoding, default width and
// the MIPS funct codes the control unit decodes into op_mult/op_div.
package mult_div_unit_pkg;

    localparam int unsigned MdWidth = 32;

    localparam logic [5:0] FunctMult = 6'h18;
    localparam logic [5:0] FunctDiv  = 6'h1a;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMult = 3'd1,
        StDiv  = 3'd2,
        StFix  = 3'd3,
        StDone = 3'd4
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit <-> multiply/divide unit bundle. div_zero exists only when
// MD_DIVZERO_EXC_EN is defined.
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MdWidth
);
    logic             op_mult;
    logic             op_div;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
`ifdef MD_DIVZERO_EXC_EN
    logic             div_zero;

    modport master (output op_mult, op_div, a_in, b_in,
                    input  busy, done, hi_out, lo_out, div_zero);
    modport slave  (input  op_mult, op_div, a_in, b_in,
                    output busy, done, hi_out, lo_out, div_zero);
`else
    modport master (output op_mult, op_div, a_in, b_in,
                    input  busy, done, hi_out, lo_out);
    modport slave  (input  op_mult, op_div, a_in, b_in,
                    output busy, done, hi_out, lo_out);
`endif
endinterface

// File: rtl/mult_div_unit_md_iter_core.sv
// One combinational iteration: radix-2 Booth step (mode_div=0) or restoring-division step
// (mode_div=1) over the shared {acc, low, qm1} working registers.
module mult_div_unit_md_iter_core
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MdWidth
) (
    input  logic             mode_div,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] low,
    input  logic             qm1,
    input  logic [WIDTH-1:0] opd,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] low_next,
    output logic             qm1_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        acc_next = acc;
        low_next = low;
        qm1_next = qm1;
        sum      = acc;
        r_sh     = '0;
        diff     = '0;
        if (mode_div) begin
            r_sh = {acc[WIDTH-1:0], low[WIDTH-1]};
            diff = {1'b0, r_sh} - {2'b00, opd};
            if (!diff[WIDTH+1]) begin
                acc_next = diff[WIDTH:0];
                low_next = {low[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = r_sh;
                low_next = {low[WIDTH-2:0], 1'b0};
            end
        end else begin
            // acc carries one guard bit so -2^(W-1) * -2^(W-1) cannot overflow
            case ({low[0], qm1})
                2'b01:   sum = acc + {opd[WIDTH-1], opd};
                2'b10:   sum = acc - {opd[WIDTH-1], opd};
                default: sum = acc;
            endcase
            acc_next = {sum[WIDTH], sum[WIDTH:1]};
            low_next = {sum[0], low[WIDTH-1:1]};
            qm1_next = low[0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MIPS mult/div unit (Booth multiply, restoring divide + sign fix-up).
// MD_DIVZERO_EXC_EN: zero divisor skips to DONE, keeps HI/LO and raises sticky div_zero.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = MdWidth,
    parameter int unsigned CNT_W = 6
) (
    input logic           clk,
    input logic           reset,
    mult_div_unit_if.slave md
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] low_q;
    logic             qm1_q;
    logic [WIDTH-1:0] opd_q;
    logic             sgn_quo_q;
    logic             sgn_rem_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] low_next;
    logic             qm1_next;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign abs_a = md.a_in[WIDTH-1] ? -md.a_in : md.a_in;
    assign abs_b = md.b_in[WIDTH-1] ? -md.b_in : md.b_in;

    mult_div_unit_md_iter_core #(
        .WIDTH(WIDTH)
    ) u_md_iter_core (
        .mode_div (state_q == StDiv),
        .acc      (acc_q),
        .low      (low_q),
        .qm1      (qm1_q),
        .opd      (opd_q),
        .acc_next (acc_next),
        .low_next (low_next),
        .qm1_next (qm1_next)
    );

`ifdef MD_DIVZERO_EXC_EN
    logic div_zero_q;
    assign md.div_zero = div_zero_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            low_q      <= '0;
            qm1_q      <= 1'b0;
            opd_q      <= '0;
            sgn_quo_q  <= 1'b0;
            sgn_rem_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MD_DIVZERO_EXC_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            // Outputs lag the state by one cycle, so done is seen while state_q is back in
            // IDLE; done_q then blocks a start during that cycle.
            busy_q <= (state_q == StMult) || (state_q == StDiv) || (state_q == StFix);
            done_q <= (state_q == StDone);
            case (state_q)
                StIdle: begin
                    if (!done_q && md.op_mult) begin
                        state_q <= StMult;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        low_q   <= md.b_in;
                        qm1_q   <= 1'b0;
                        opd_q   <= md.a_in;
`ifdef MD_DIVZERO_EXC_EN
                        div_zero_q <= 1'b0;
`endif
                    end else if (!done_q && md.op_div) begin
`ifdef MD_DIVZERO_EXC_EN
                        div_zero_q <= (md.b_in == '0);
                        if (md.b_in == '0) begin
                            state_q <= StDone;
                        end else
`endif
                        begin
                            state_q   <= StDiv;
                            cnt_q     <= '0;
                            acc_q     <= '0;
                            low_q     <= abs_a;
                            qm1_q     <= 1'b0;
                            opd_q     <= abs_b;
                            sgn_quo_q <= md.a_in[WIDTH-1] ^ md.b_in[WIDTH-1];
                            sgn_rem_q <= md.a_in[WIDTH-1];
                        end
                    end
                end
                StMult: begin
                    acc_q <= acc_next;
                    low_q <= low_next;
                    qm1_q <= qm1_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LastCnt) begin
                        hi_q    <= acc_next[WIDTH-1:0];
                        lo_q    <= low_next;
                        state_q <= StDone;
                    end
                end
                StDiv: begin
                    acc_q <= acc_next;
                    low_q <= low_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LastCnt) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hi_q    <= sgn_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    lo_q    <= sgn_quo_q ? -low_q : low_q;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign md.busy   = busy_q;
    assign md.done   = done_q;
    assign md.hi_out = hi_q;
    assign md.lo_out = lo_q;

endmodule
